// File: rtl/t03_lsu_pkg.sv
// Shared types and helpers for the t03 load/store unit: FSM state, funct3 encodings,
// byte-lane select and access legality.
package t03_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] lsu_sel(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001 << offset;
      2'b01:   sel = 4'b0011 << offset;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic lsu_access_ok(input logic is_load, input logic [2:0] f3,
                                         input logic [1:0] offset);
    logic legal;
    logic aligned;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = is_load;
      default:          legal = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   aligned = ~offset[0];
      2'b10:   aligned = (offset == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/t03_load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/half from the bus word and
// sign- or zero-extends it according to funct3.
module t03_load_formatter
  import t03_lsu_pkg::*;
(
  input  logic [31:0] i_mem_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
  end

  assign w_half = i_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    o_data = i_mem_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_mem_rdata;
    endcase
  end

endmodule

// File: rtl/t03_load_store_unit.sv
// Load/store unit: one req/ack bus transaction per load/store, freezes the core meanwhile.
// Define T03_LSU_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES un-acked REQ cycles.
module t03_load_store_unit
  import t03_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] load_data,
  output logic        freeze,
  output logic        fault,
  output logic        busy_err
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_next;

  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_sel;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_load_data;
  logic        r_fault;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic        r_is_load;

  logic        w_single;
  logic        w_ok;
  logic        w_timeout;
  logic [31:0] w_wdata;
  logic [31:0] w_fmt;

  assign w_single = read_req ^ write_req;
  assign w_ok     = lsu_access_ok(read_req, funct3, addr[1:0]);

  always_comb begin
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00:   w_wdata = {4{store_data[7:0]}};
      2'b01:   w_wdata = {2{store_data[15:0]}};
      default: w_wdata = store_data;
    endcase
  end

`ifdef T03_LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] r_wait_cnt;

  // Counter is zero on every REQ entry because it is held clear outside REQ.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wait_cnt <= '0;
    end else if (r_state != REQ) begin
      r_wait_cnt <= '0;
    end else if (!mem_ack) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == REQ) && !mem_ack &&
                     ((32'(r_wait_cnt) + 32'd1) == TIMEOUT_CYCLES);
`else
  assign w_timeout = 1'b0;

  // TIMEOUT_CYCLES only matters when the timeout is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  t03_load_formatter u_formatter (
    .i_mem_rdata (mem_rdata),
    .i_funct3    (r_funct3),
    .i_offset    (r_offset),
    .o_data      (w_fmt)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_single) begin
          w_state_next = w_ok ? REQ : DONE;
        end
      end
      REQ: begin
        if (mem_ack || w_timeout) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // freeze is combinational in IDLE so the issuing instruction is held the same cycle.
  always_comb begin
    freeze   = 1'b0;
    busy_err = 1'b0;
    case (r_state)
      IDLE: begin
        freeze   = w_single;
        busy_err = read_req & write_req;
      end
      REQ:     freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_sel   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_load_data <= '0;
      r_fault     <= 1'b0;
      r_funct3    <= '0;
      r_offset    <= '0;
      r_is_load   <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_single) begin
            if (w_ok) begin
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_sel   <= lsu_sel(funct3[1:0], addr[1:0]);
              r_mem_wdata <= w_wdata;
              r_funct3    <= funct3;
              r_offset    <= addr[1:0];
              r_is_load   <= read_req;
              r_mem_read  <= read_req;
              r_mem_write <= write_req;
            end else begin
              r_fault     <= 1'b1;
              r_load_data <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_is_load) begin
              r_load_data <= w_fmt;
            end
          end else if (w_timeout) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_fault     <= 1'b1;
            r_load_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_sel   = r_mem_sel;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign load_data = r_load_data;
  assign fault     = r_fault;

endmodule
